// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: shared RAM port bundle.
// master drives the request side, slave is the RAM.
interface mem_access_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MOV;
  logic          R_W;
  logic [1:0]    DT;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          MOC;
  logic [DW-1:0] mem_rdata;

  modport master (
    output MOV, R_W, DT, mem_addr, mem_wdata,
    input  MOC, mem_rdata
  );

  modport slave (
    input  MOV, R_W, DT, mem_addr, mem_wdata,
    output MOC, mem_rdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin RAM port sequencer, fetch vs data.
// Define MEM_TIMEOUT_EN to add the MOC watchdog that raises err.
module mem_access_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_if,
  input  logic [AW-1:0] if_addr,
  input  logic          req_d,
  input  logic [AW-1:0] d_addr,
  input  logic          d_rw,
  input  logic [1:0]    d_dt,
  input  logic [DW-1:0] d_wdata,
  output logic          done_if,
  output logic          done_d,
  output logic [DW-1:0] rdata,
  output logic          err,
  mem_access_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state;
  logic   last_d;
  logic   pick_if;
  logic   tmo;

  // fetch wins alone, or on contention when data won last
  assign pick_if = req_if && (!req_d || last_d);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [7:0] cnt;

  // count ACCESS cycles spent waiting for MOC
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (state != ACCESS) begin
      cnt <= '0;
    end else if (!mem.MOC && cnt != TMO) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tmo = (state == ACCESS) && !mem.MOC
            && (cnt == TMO);
`else
  assign tmo = 1'b0;
  // TIMEOUT is 1..255, so err is constant 0 here
  assign err = (TIMEOUT == 0);
`endif

  // request sequencing and RAM handshake
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      mem.MOV       <= 1'b0;
      mem.R_W       <= 1'b1;
      mem.DT        <= 2'b00;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rdata         <= '0;
      done_if       <= 1'b0;
      done_d        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err           <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (!mem.MOC && (req_if || req_d)) begin
            last_d  <= !pick_if;
            mem.MOV <= 1'b1;
            state   <= ACCESS;
            if (pick_if) begin
              mem.R_W      <= 1'b1;
              mem.DT       <= 2'b10;
              mem.mem_addr <= if_addr;
            end else begin
              mem.R_W       <= d_rw;
              mem.DT        <= d_dt;
              mem.mem_addr  <= d_addr;
              mem.mem_wdata <= d_wdata;
            end
          end
        end
        ACCESS: begin
          if (mem.MOC || tmo) begin
            mem.MOV <= 1'b0;
            if (mem.MOC && mem.R_W) begin
              rdata <= mem.mem_rdata;
            end
            done_if <= !last_d;
            done_d  <= last_d;
`ifdef MEM_TIMEOUT_EN
            err     <= !mem.MOC;
`endif
            state   <= DONE;
          end
        end
        DONE: begin
          done_if <= 1'b0;
          done_d  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          err     <= 1'b0;
`endif
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequences every access to the shared RAM port of the ARM datapath and arbitrates between two requesters: the instruction-fetch path (IR load) and the data path (MAR/MDR load and store). It owns the RAM handshake signals `MOV`, `R_W`, `DT` and waits for `MOC`, latching read data and returning a one-cycle completion pulse to the granted requester. The control unit no longer drives `MOV` directly. It raises a request and waits for the matching done pulse.

## Interface
- `AW`, default 32, address width.
- `DW`, default 32, data width.
- `TIMEOUT`, default 15, maximum number of cycles to wait for `MOC`. Used only with `MEM_TIMEOUT_EN`. Legal range is 1 to 255.
- `clk` in 1: the only clock. All state changes on the rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `req_if` in 1: instruction-fetch request. Level-held.
- `if_addr` in AW: fetch address.
- `req_d` in 1: data request. Level-held.
- `d_addr` in AW: data address.
- `d_rw` in 1: data direction. 1 = read, 0 = write.
- `d_dt` in 2: data size. 00 = byte, 01 = halfword, 10 = word, 11 = doubleword.
- `d_wdata` in DW: store data.
- `done_if` out 1: one-cycle pulse when the fetch access completes.
- `done_d` out 1: one-cycle pulse when the data access completes.
- `rdata` out DW: read data latched from the RAM. Valid from the cycle in which a done pulse is high until the next completed read.
- `err` out 1: one-cycle pulse, coincident with the done pulse, when the access timed out.
- `MOV` out 1: memory operation valid.
- `R_W` out 1: 1 = read, 0 = write.
- `DT` out 2: access size.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `MOC` in 1: memory operation complete.
- `mem_rdata` in DW: memory read data.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE. After reset it is in IDLE.
- Transitions out of IDLE:
  - If `MOC` is 0 and at least one request is high, arbitrate, latch the winner's address, direction, size and write data, set `MOV`=1, and go to ACCESS.
  - If `MOC` is still 1 (stale completion from the previous access), remain in IDLE regardless of requests.
- Arbitration is round-robin:
  - If only one request is high, that requester wins.
  - If both are high, the requester that did not win last wins.
  - `last_grant` resets to data, so the fetch path wins the first contention.
- Fetch accesses always drive `R_W`=1 and `DT`=10. The `d_*` inputs are ignored for a fetch grant.
- ACCESS state:
  - Hold `MOV` and all memory outputs stable.
  - When `MOC` is 1, latch `mem_rdata` into `rdata` (reads only), drop `MOV`, pulse the winner's done output, and go to DONE.
  - A write leaves `rdata` unchanged.
- DONE state: done pulse is high and `MOV`=0. Go to IDLE unconditionally.
- A requester must drop its request during its DONE cycle. A request still high when the FSM reaches IDLE is treated as a new access.
- Request inputs must stay stable from request assertion until done. A request withdrawn while the FSM is in ACCESS does not abort the access, and its done pulse is still issued.
- A request arriving during ACCESS or DONE waits. Nothing is lost.
- Asynchronous reset while in ACCESS aborts the access: `MOV` drops immediately, no done pulse is issued, and the FSM returns to IDLE.
- Reset values: `MOV`=0, `R_W`=1, `DT`=00, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, `done_if`=0, `done_d`=0, `err`=0, `last_grant`=data, timeout counter=0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Edge 0: request sampled high in IDLE. From edge 0, `MOV`=1.
- Edge k: first edge in ACCESS at which `MOC`=1. From edge k, the done pulse is high and `MOV`=0.
- Edge k+1: FSM returns to IDLE.
- The minimum access, with `MOC` already high at edge 1, takes 3 cycles from request sample to IDLE.
- Back-to-back grants are separated by at least one IDLE cycle.
- Throughput is at most one access per 3 cycles.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with `MOC`=0.
  - When the counter reaches `TIMEOUT` with `MOC` still 0, drop `MOV`, pulse the winner's done output together with `err`, leave `rdata` unchanged, and go to DONE.
  - `MOC` arriving on the same edge as the timeout takes precedence: normal completion, `err`=0.
- `MEM_TIMEOUT_EN` undefined:
  - ACCESS waits for `MOC` indefinitely.
  - `err` is tied to 0 and no counter is synthesized.

## Test plan
- Single fetch:
  - Stimulus: `req_if`=1, `if_addr`=0x100. Memory returns `MOC` 2 cycles after `MOV` with `mem_rdata`=0xE3A01005.
  - Response: `MOV`=1, `R_W`=1, `DT`=10, `mem_addr`=0x100. `done_if` pulses once and `rdata`=0xE3A01005.
- Data write:
  - Stimulus: `req_d`=1, `d_rw`=0, `d_dt`=00, `d_addr`=0x23, `d_wdata`=0xAB.
  - Response: `R_W`=0, `DT`=00, `mem_wdata`=0xAB. `done_d` pulses and `rdata` keeps its previous value.
- Contention:
  - Stimulus: both requests held high from reset for 3 accesses, with `MOC` immediate.
  - Response: grant order is fetch, data, fetch, and the done pulses alternate.
- Stale `MOC`:
  - Stimulus: `MOC` held 1 for 2 cycles after DONE while `req_d`=1.
  - Response: `MOV` stays 0 until the first IDLE cycle with `MOC`=0.
- Reset mid-access:
  - Stimulus: `clr`=0 asserted between edges during ACCESS.
  - Response: `MOV`=0 immediately, no done pulse, and all outputs at their reset values.
- Timeout (`MEM_TIMEOUT_EN` defined, `TIMEOUT`=4):
  - Stimulus: a data read with no `MOC`.
  - Response: `done_d` and `err` pulse together 5 cycles after `MOV` rises.
  - Stimulus: rerun with `MOC` arriving on the timeout edge.
  - Response: `err`=0.
